// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
//   start : conversion request (requester -> converter)
//   bin   : unsigned binary value, WIDTH bits (requester -> converter)
//   busy  : conversion in progress (converter -> requester)
//   done  : one-cycle pulse, first cycle a new result is visible
//   bcd   : packed BCD result {thousands, hundreds, tens, units}
//   ovf   : last converted value was above 9999
interface bin_to_bcd_seq_if #(
  parameter int unsigned WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [15:0]      bcd;
  logic             ovf;

  // Requester side (e.g. whatever feeds the display driver)
  modport master (
    output start, bin,
    input  busy, done, bcd, ovf
  );

  // Converter side
  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf
  );

endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per clock.
// The 16-bit packed BCD result feeds a 4-digit seven-segment driver directly and
// is held stable between conversions.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : bin_to_bcd_seq_if.slave -- start/bin in; busy/done/bcd/ovf out
module bin_to_bcd_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned DIGITS = 5;
  localparam int unsigned ACC_W  = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   acc_adj_c;
  // One bit wider than the accumulator so the final shift-out also feeds ovf
  logic [ACC_W:0]     acc_shift_c;

  // Per-digit add-3 for any digit >= 5; 4-bit add, carry absorbed by the shift
  always_comb begin
    acc_adj_c = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj_c[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end else begin
        acc_adj_c[4*i +: 4] = acc_q[4*i +: 4];
      end
    end
    acc_shift_c = {acc_adj_c, sh_q[WIDTH-1]};
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= 16'h0000;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          acc_d   = '0;
          sh_d    = bus.bin;
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        acc_d = acc_shift_c[ACC_W-1:0];
        sh_d  = WIDTH'(sh_q << 1);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = acc_shift_c[15:0];
          ovf_d   = |acc_shift_c[ACC_W:16];
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one iteration per clock.
- Feeds the 4-digit seven-segment display driver. Its 16-bit packed-BCD output connects directly to the driver's 16-bit `in` input, so the display shows decimal instead of hex.
- Uses a start/busy/done handshake.
- Holds the last result stable between conversions, so the display never shows intermediate values.

Parameters:
- WIDTH, 16: width of the binary input and number of shift iterations. Legal range is 1..16.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  conversion request; sampled only in IDLE or DONE.
- bin  in  WIDTH  unsigned binary value; sampled only on the edge that accepts start.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse; high for the single cycle in which a new result is first visible.
- bcd  out  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- ovf  out  1  high when the last converted value was above 9999.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous, active-high, and takes priority over all other activity.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, bcd = 16'h0000, ovf = 0
  - internal shift register and iteration counter cleared
- Internal scratch: 20-bit BCD accumulator (5 digits) plus a WIDTH-bit binary shift register. Iteration counter width is clog2(WIDTH+1).
- States:
  - IDLE: busy = 0, done = 0. If start = 1:
    - latch bin into the shift register
    - clear the accumulator
    - load counter = WIDTH
    - go to SHIFT
  - SHIFT: busy = 1. Each edge performs one iteration:
    - every accumulator digit >= 5 gets +3
    - then shift {accumulator, shift register} left by one; the binary MSB enters accumulator bit 0
    - decrement the counter
    - on the edge where the counter goes from 1 to 0: register bcd = accumulator result [15:0], ovf = (result digit 4 != 0), done = 1, go to DONE
    - the +3 adjust and the shift are combinational within a single edge; each digit's +3 is a 4-bit add with the carry absorbed by the shift.
  - DONE: busy = 0, done = 1 for exactly this one cycle.
    - If start = 1: accept a new conversion exactly as from IDLE; the next state is SHIFT and done drops.
    - Otherwise go to IDLE.
- Latency: start accepted at edge E0; iterations on E1..E_WIDTH; bcd, ovf and done update at E_WIDTH (edge E16 for the default). Back-to-back throughput is one result per WIDTH+1 cycles.
- Ignored inputs:
  - start is ignored while in SHIFT; no queueing.
  - bin changes after the accepting edge have no effect.
- Output stability: bcd and ovf change only at the completion edge or on reset, and otherwise hold their previous values.
- Overflow: values 10000..65535 produce ovf = 1 with bcd = the low four decimal digits (e.g. 65535 gives 16'h5535). ovf can only be 1 when WIDTH >= 14.
- Reset mid-conversion: aborts the conversion, no done pulse, bcd = 0, ovf = 0, IDLE on the next cycle.
- Simultaneous start and rst: rst wins; the start is lost.
- WIDTH < 16: bin is zero-extended conceptually; the result is identical to converting the same value at WIDTH = 16.

Test Plan:
- Reset, then start with bin = 16'd1234 (0x04D2) -> busy high on E1..E16, done high for exactly one cycle after E16, bcd = 16'h1234, ovf = 0.
- Boundaries: bin = 0 -> 16'h0000; bin = 9999 -> 16'h9999, ovf = 0; bin = 10000 -> 16'h0000, ovf = 1; bin = 65535 -> 16'h5535, ovf = 1.
- start pulsed at E5 of an active conversion, and bin changed mid-conversion -> no effect; the single result matches the originally latched bin.
- start held high continuously with bin = 42, then 7 -> conversions chain every 17 cycles; done pulses with bcd 16'h0042, then 16'h0007.
- rst asserted at E8 of a conversion of 5678 -> no done pulse, bcd = 0, busy = 0 next cycle; a subsequent conversion of 5678 gives 16'h5678.
- Random sweep of 2000 values, compared against a reference model of decimal digits mod 10000 plus (value > 9999) -> zero mismatches; bcd never changes outside done cycles.
